// File: rtl/alu_sys_ctrl_pkg.sv
// alu_sys_ctrl_pkg: shared types and constants for the ALU command controller.
//  - DATA_WIDTH / RES_WIDTH : byte and ALU result widths
//  - CMD_OP_AB_DFLT / CMD_OP_FUN_DFLT : default frame header bytes
//  - ALU_FUN_* : ALU function code values
//  - state_e : controller FSM state encoding
//  - res_byte() : selects the low or high byte of a result word
package alu_sys_ctrl_pkg;

   localparam int DATA_WIDTH = 8;
   localparam int RES_WIDTH  = 2 * DATA_WIDTH;

   localparam logic [DATA_WIDTH-1:0] CMD_OP_AB_DFLT  = 8'hCC;
   localparam logic [DATA_WIDTH-1:0] CMD_OP_FUN_DFLT = 8'hDD;

   localparam logic [3:0] ALU_FUN_ADD  = 4'h0;
   localparam logic [3:0] ALU_FUN_SUB  = 4'h1;
   localparam logic [3:0] ALU_FUN_MUL  = 4'h2;
   localparam logic [3:0] ALU_FUN_DIV  = 4'h3;
   localparam logic [3:0] ALU_FUN_AND  = 4'h4;
   localparam logic [3:0] ALU_FUN_OR   = 4'h5;
   localparam logic [3:0] ALU_FUN_NAND = 4'h6;
   localparam logic [3:0] ALU_FUN_NOR  = 4'h7;
   localparam logic [3:0] ALU_FUN_XOR  = 4'h8;
   localparam logic [3:0] ALU_FUN_XNOR = 4'h9;
   localparam logic [3:0] ALU_FUN_CMPEQ = 4'hA;
   localparam logic [3:0] ALU_FUN_CMPGT = 4'hB;
   localparam logic [3:0] ALU_FUN_CMPLT = 4'hC;
   localparam logic [3:0] ALU_FUN_SHR  = 4'hD;
   localparam logic [3:0] ALU_FUN_SHL  = 4'hE;
   localparam logic [3:0] ALU_FUN_NOP  = 4'hF;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      GET_A    = 3'd1,
      GET_B    = 3'd2,
      GET_FUN  = 3'd3,
      EXEC     = 3'd4,
      WAIT_RES = 3'd5,
      SEND_LSB = 3'd6,
      SEND_MSB = 3'd7
   } state_e;

   function automatic logic [DATA_WIDTH-1:0] res_byte(input logic [RES_WIDTH-1:0] res,
                                                      input logic             hi);
      logic [DATA_WIDTH-1:0] b;
      if (hi) begin
         b = res[RES_WIDTH-1:DATA_WIDTH];
      end else begin
         b = res[DATA_WIDTH-1:0];
      end
      return b;
   endfunction

endpackage

// File: rtl/alu_sys_ctrl_if.sv
// alu_sys_ctrl_if: bundle of the controller's RX, ALU and TX FIFO signals.
//  master : controller side (drives ALU operands/enable and TX FIFO writes)
//  slave  : environment side (RX path, ALU, TX FIFO)
//  ALU_CLK_EN exists only when ALU_CLK_GATE_EN is defined.
interface alu_sys_ctrl_if;
   import alu_sys_ctrl_pkg::*;

   logic [DATA_WIDTH-1:0] RX_P_DATA;
   logic                  RX_D_VLD;
   logic [RES_WIDTH-1:0]  ALU_OUT;
   logic                  OUT_Valid;
   logic                  FIFO_FULL;
   logic [DATA_WIDTH-1:0] ALU_A;
   logic [DATA_WIDTH-1:0] ALU_B;
   logic [3:0]            ALU_FUN;
   logic                  ALU_EN;
   logic [DATA_WIDTH-1:0] TX_P_DATA;
   logic                  TX_D_VLD;
   logic                  FRAME_ERR;
`ifdef ALU_CLK_GATE_EN
   logic                  ALU_CLK_EN;
`endif

   modport master (
      input  RX_P_DATA, RX_D_VLD, ALU_OUT, OUT_Valid, FIFO_FULL,
      output ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD, FRAME_ERR
`ifdef ALU_CLK_GATE_EN
      , output ALU_CLK_EN
`endif
   );

   modport slave (
      output RX_P_DATA, RX_D_VLD, ALU_OUT, OUT_Valid, FIFO_FULL,
      input  ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD, FRAME_ERR
`ifdef ALU_CLK_GATE_EN
      , input ALU_CLK_EN
`endif
   );

endinterface

// File: rtl/alu_sys_ctrl_res_tx_ser.sv
// res_tx_ser: holds the captured ALU result and presents one byte of it to
// the TX FIFO. The write strobe is combinational on fifo_full_i so a write is
// never issued while the FIFO is full; the byte stays stable while stalled.
//  clk, rst_n   : clock, async active-low reset
//  cap_i        : load res_i into the result register
//  res_i        : ALU result word
//  send_i       : a byte is pending; msb_i selects the high byte
//  fifo_full_i  : FIFO back-pressure
//  tx_data_o    : byte to FIFO (0 when nothing is pending)
//  tx_vld_o     : FIFO write strobe
module res_tx_ser
   import alu_sys_ctrl_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cap_i,
   input  logic [RES_WIDTH-1:0]  res_i,
   input  logic                  send_i,
   input  logic                  msb_i,
   input  logic                  fifo_full_i,
   output logic [DATA_WIDTH-1:0] tx_data_o,
   output logic                  tx_vld_o
);

   logic [RES_WIDTH-1:0] res_q;

   // Result register, loaded only on the capture strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q <= {RES_WIDTH{1'b0}};
      end else if (cap_i) begin
         res_q <= res_i;
      end else begin
         res_q <= res_q;
      end
   end

   // Byte select and back-pressured write strobe.
   always_comb begin
      tx_data_o = {DATA_WIDTH{1'b0}};
      tx_vld_o  = 1'b0;
      if (send_i) begin
         tx_data_o = res_byte(res_q, msb_i);
         tx_vld_o  = !fifo_full_i;
      end else begin
         tx_vld_o  = 1'b0;
      end
   end

endmodule

// File: rtl/alu_sys_ctrl.sv
// alu_sys_ctrl: command controller in front of the ALU. Parses RX byte frames
// (CC,A,B,FUN or DD,FUN), drives ALU operands/function and a one-cycle enable,
// captures the ALU result on OUT_Valid and writes it LSB-first to the TX FIFO.
//  CLK  : block clock
//  RST  : asynchronous active-low reset
//  bus  : alu_sys_ctrl_if.master (RX byte/strobe, ALU operands/result,
//         TX FIFO byte/strobe/full, FRAME_ERR pulse)
// Build option: define ALU_CLK_GATE_EN to add bus.ALU_CLK_EN, a registered
// ALU clock-gate enable held from EXEC through the result capture cycle.
module alu_sys_ctrl
   import alu_sys_ctrl_pkg::*;
#(
   parameter logic [DATA_WIDTH-1:0] CMD_OP_AB  = CMD_OP_AB_DFLT,
   parameter logic [DATA_WIDTH-1:0] CMD_OP_FUN = CMD_OP_FUN_DFLT
) (
   input  logic           CLK,
   input  logic           RST,
   alu_sys_ctrl_if.master bus
);

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] a_q, a_d;
   logic [DATA_WIDTH-1:0] b_q, b_d;
   logic [3:0]            fun_q, fun_d;
   logic                  en_q, en_d;
   logic                  err_q, err_d;
   logic                  cap_s;
   logic                  send_s;
   logic                  msb_s;
   logic                  tx_vld_s;
   logic [DATA_WIDTH-1:0] tx_data_s;

   assign send_s = (state_q == SEND_LSB) || (state_q == SEND_MSB);
   assign msb_s  = (state_q == SEND_MSB);

   // Next-state, operand latching and frame-error detection.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      fun_d   = fun_q;
      err_d   = 1'b0;
      cap_s   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.RX_D_VLD) begin
               if (bus.RX_P_DATA == CMD_OP_AB) begin
                  state_d = GET_A;
               end else if (bus.RX_P_DATA == CMD_OP_FUN) begin
                  state_d = GET_FUN;
               end else begin
                  err_d = 1'b1;
               end
            end else begin
               state_d = IDLE;
            end
         end
         GET_A: begin
            if (bus.RX_D_VLD) begin
               a_d     = bus.RX_P_DATA;
               state_d = GET_B;
            end else begin
               state_d = GET_A;
            end
         end
         GET_B: begin
            if (bus.RX_D_VLD) begin
               b_d     = bus.RX_P_DATA;
               state_d = GET_FUN;
            end else begin
               state_d = GET_B;
            end
         end
         GET_FUN: begin
            if (bus.RX_D_VLD) begin
               fun_d   = bus.RX_P_DATA[3:0];
               state_d = EXEC;
            end else begin
               state_d = GET_FUN;
            end
         end
         EXEC: begin
            err_d   = bus.RX_D_VLD;
            state_d = WAIT_RES;
         end
         WAIT_RES: begin
            err_d = bus.RX_D_VLD;
            // ALU_OUT falls back to 0 after the enable, so only OUT_Valid marks the result.
            if (bus.OUT_Valid) begin
               cap_s   = 1'b1;
               state_d = SEND_LSB;
            end else begin
               state_d = WAIT_RES;
            end
         end
         SEND_LSB: begin
            err_d = bus.RX_D_VLD;
            if (tx_vld_s) begin
               state_d = SEND_MSB;
            end else begin
               state_d = SEND_LSB;
            end
         end
         SEND_MSB: begin
            err_d = bus.RX_D_VLD;
            if (tx_vld_s) begin
               state_d = IDLE;
            end else begin
               state_d = SEND_MSB;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      en_d = (state_d == EXEC);
   end

   // FSM, operand and pulse registers.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
         a_q     <= {DATA_WIDTH{1'b0}};
         b_q     <= {DATA_WIDTH{1'b0}};
         fun_q   <= 4'h0;
         en_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         fun_q   <= fun_d;
         en_q    <= en_d;
         err_q   <= err_d;
      end
   end

`ifdef ALU_CLK_GATE_EN
   logic clk_en_q;

   // Clock-gate enable: high in EXEC and WAIT_RES, so it already covers the ALU_EN cycle.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         clk_en_q <= 1'b0;
      end else begin
         clk_en_q <= (state_d == EXEC) || (state_d == WAIT_RES);
      end
   end

   assign bus.ALU_CLK_EN = clk_en_q;
`endif

   res_tx_ser u_res_tx_ser (
      .clk         (CLK),
      .rst_n       (RST),
      .cap_i       (cap_s),
      .res_i       (bus.ALU_OUT),
      .send_i      (send_s),
      .msb_i       (msb_s),
      .fifo_full_i (bus.FIFO_FULL),
      .tx_data_o   (tx_data_s),
      .tx_vld_o    (tx_vld_s)
   );

   assign bus.ALU_A     = a_q;
   assign bus.ALU_B     = b_q;
   assign bus.ALU_FUN   = fun_q;
   assign bus.ALU_EN    = en_q;
   assign bus.FRAME_ERR = err_q;
   assign bus.TX_P_DATA = tx_data_s;
   assign bus.TX_D_VLD  = tx_vld_s;

endmodule

// File: tb/tb_alu_sys_ctrl.sv
// tb_alu_sys_ctrl: scoreboard bench for alu_sys_ctrl. Stimulus pushes the
// expected ALU operations and TX bytes (from a reference model of the frame
// rules) into queues; a monitor pops and compares whenever the DUT enables the
// ALU or writes the FIFO. A behavioural registered ALU answers ALU_EN.
module tb_alu_sys_ctrl;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic [3:0] f;
   } op_t;

   logic CLK = 1'b0;
   logic RST;

   alu_sys_ctrl_if bus();

   alu_sys_ctrl dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   int         checks   = 0;
   int         failures = 0;
   int         err_exp  = 0;
   int         err_seen = 0;
   logic [7:0] m_a      = 8'h00;
   logic [7:0] m_b      = 8'h00;
   logic [7:0] tx_exp_q[$];
   op_t        op_exp_q[$];
   bit         force_full = 1'b0;
   bit         rand_full  = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference ALU behaviour, 8-bit operands zero-extended to a 16-bit result.
   function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] f);
      logic [15:0] x;
      logic [15:0] y;
      x = {8'h00, a};
      y = {8'h00, b};
      case (f)
         4'h0: return x + y;
         4'h1: return x - y;
         4'h2: return x * y;
         4'h3: return (b == 8'h00) ? 16'h0000 : x / y;
         4'h4: return x & y;
         4'h5: return x | y;
         4'h6: return {8'h00, ~(a & b)};
         4'h7: return {8'h00, ~(a | b)};
         4'h8: return x ^ y;
         4'h9: return {8'h00, ~(a ^ b)};
         4'hA: return (a == b) ? 16'h0001 : 16'h0000;
         4'hB: return (a > b) ? 16'h0002 : 16'h0000;
         4'hC: return (a < b) ? 16'h0003 : 16'h0000;
         4'hD: return x >> 1;
         4'hE: return x << 1;
         default: return 16'h0000;
      endcase
   endfunction

   task automatic send_byte(input logic [7:0] b);
      @(negedge CLK);
      bus.RX_P_DATA = b;
      bus.RX_D_VLD  = 1'b1;
      @(negedge CLK);
      bus.RX_D_VLD  = 1'b0;
   endtask

   task automatic gap();
      repeat ($urandom_range(0, 2)) @(negedge CLK);
   endtask

   // Issue one command frame and record what it must produce.
   task automatic frame(input bit ab, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] f);
      logic [15:0] r;
      logic [3:0]  hi;
      if (ab) begin
         m_a = a;
         m_b = b;
      end
      r  = alu_ref(m_a, m_b, f);
      hi = 4'($urandom_range(0, 15));
      op_exp_q.push_back({m_a, m_b, f});
      tx_exp_q.push_back(r[7:0]);
      tx_exp_q.push_back(r[15:8]);
      send_byte(ab ? 8'hCC : 8'hDD);
      gap();
      if (ab) begin
         send_byte(a);
         gap();
         send_byte(b);
         gap();
      end
      send_byte({hi, f});
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((tx_exp_q.size() != 0) && (n < 300)) begin
         @(negedge CLK);
         n++;
      end
      chk({name, "_drain"}, tx_exp_q.size(), 0);
      tx_exp_q.delete();
      repeat (3) @(negedge CLK);
      chk({name, "_frame_err"}, err_seen, err_exp);
      err_seen = err_exp;
   endtask

   // Behavioural registered ALU: answers an enable one cycle later, 0 otherwise.
   initial begin
      logic       en;
      logic [7:0] ra;
      logic [7:0] rb;
      logic [3:0] rf;
      bus.ALU_OUT   = 16'h0000;
      bus.OUT_Valid = 1'b0;
      forever begin
         @(negedge CLK);
         en = bus.ALU_EN;
         ra = bus.ALU_A;
         rb = bus.ALU_B;
         rf = bus.ALU_FUN;
         @(posedge CLK);
         #1;
         bus.OUT_Valid = en;
         bus.ALU_OUT   = en ? alu_ref(ra, rb, rf) : 16'h0000;
      end
   end

   // TX FIFO full driver.
   initial begin
      bus.FIFO_FULL = 1'b0;
      forever begin
         @(negedge CLK);
         #1;
         if (force_full) begin
            bus.FIFO_FULL = 1'b1;
         end else if (rand_full) begin
            bus.FIFO_FULL = ($urandom_range(0, 3) == 0);
         end else begin
            bus.FIFO_FULL = 1'b0;
         end
      end
   end

   // Monitor: compares every ALU enable and FIFO write against the queues.
   initial begin
      op_t o;
      forever begin
         @(negedge CLK);
         #2;
         if (bus.FRAME_ERR) err_seen++;
         if (bus.ALU_EN) begin
            chk("alu_en_expected", (op_exp_q.size() != 0), 1);
`ifdef ALU_CLK_GATE_EN
            chk("clk_en_at_alu_en", bus.ALU_CLK_EN, 1);
`endif
            if (op_exp_q.size() != 0) begin
               o = op_exp_q.pop_front();
               chk("alu_a", bus.ALU_A, o.a);
               chk("alu_b", bus.ALU_B, o.b);
               chk("alu_fun", bus.ALU_FUN, o.f);
            end
         end
`ifdef ALU_CLK_GATE_EN
         if (bus.OUT_Valid) chk("clk_en_at_capture", bus.ALU_CLK_EN, 1);
`endif
         if (bus.TX_D_VLD) begin
            chk("tx_vld_while_full", bus.FIFO_FULL, 0);
            chk("tx_expected", (tx_exp_q.size() != 0), 1);
`ifdef ALU_CLK_GATE_EN
            chk("clk_en_in_send", bus.ALU_CLK_EN, 0);
`endif
            if (tx_exp_q.size() != 0) begin
               chk("tx_byte", bus.TX_P_DATA, tx_exp_q.pop_front());
            end
         end
      end
   end

   task automatic check_outputs_zero(input string name);
      chk({name, "_alu_a"}, bus.ALU_A, 0);
      chk({name, "_alu_b"}, bus.ALU_B, 0);
      chk({name, "_alu_fun"}, bus.ALU_FUN, 0);
      chk({name, "_alu_en"}, bus.ALU_EN, 0);
      chk({name, "_tx_data"}, bus.TX_P_DATA, 0);
      chk({name, "_tx_vld"}, bus.TX_D_VLD, 0);
      chk({name, "_frame_err"}, bus.FRAME_ERR, 0);
`ifdef ALU_CLK_GATE_EN
      chk({name, "_clk_en"}, bus.ALU_CLK_EN, 0);
`endif
   endtask

   initial begin
      logic [7:0] hb;
      int         k;
      RST           = 1'b0;
      bus.RX_P_DATA = 8'h00;
      bus.RX_D_VLD  = 1'b0;
      repeat (3) @(negedge CLK);
      #2;
      check_outputs_zero("reset");
      @(negedge CLK);
      RST = 1'b1;

      // 7+5 with the FIFO full across the LSB slot.
      force_full = 1'b1;
      frame(1'b1, 8'h07, 8'h05, 4'h0);
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK);
         #2;
         chk("stall_no_write", bus.TX_D_VLD, 0);
         if (i >= 3) begin
            chk("stall_data_stable", bus.TX_P_DATA, 8'h0C);
`ifdef ALU_CLK_GATE_EN
            chk("stall_clk_en", bus.ALU_CLK_EN, 0);
`endif
         end
      end
      @(negedge CLK);
      force_full = 1'b0;
      #2;
      chk("release_write", bus.TX_D_VLD, 1);
      chk("release_data", bus.TX_P_DATA, 8'h0C);
      wait_drain("add_stall");

      // Multiply then reuse the operands with DD.
      frame(1'b1, 8'h10, 8'h20, 4'h2);
      wait_drain("mul");
      frame(1'b0, 8'h00, 8'h00, 4'h0);
      wait_drain("dd_reuse");
      frame(1'b0, 8'h00, 8'h00, 4'hF);
      wait_drain("fun_f");

      // Unknown header.
      send_byte(8'hAB);
      err_exp++;
      wait_drain("bad_header");

      // Byte arriving while the result is pending.
      frame(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 4'h8);
      send_byte(8'($urandom_range(0, 255)));
      err_exp++;
      wait_drain("busy_byte");

      // Reset in the middle of a frame wipes the stored operands.
      send_byte(8'hCC);
      send_byte(8'h07);
      @(negedge CLK);
      RST = 1'b0;
      m_a = 8'h00;
      m_b = 8'h00;
      #1;
      check_outputs_zero("mid_reset");
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      frame(1'b0, 8'h00, 8'h00, 4'h0);
      wait_drain("after_reset");

      // Randomized frames with random FIFO back-pressure.
      rand_full = 1'b1;
      for (int n = 0; n < 40; n++) begin
         k = $urandom_range(0, 9);
         if (k < 4) begin
            frame(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  4'($urandom_range(0, 15)));
         end else if (k < 7) begin
            frame(1'b0, 8'h00, 8'h00, 4'($urandom_range(0, 15)));
         end else if (k < 9) begin
            hb = 8'($urandom_range(0, 255));
            if ((hb == 8'hCC) || (hb == 8'hDD)) hb = 8'hAB;
            send_byte(hb);
            err_exp++;
         end else begin
            frame(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  4'($urandom_range(0, 15)));
            send_byte(8'($urandom_range(0, 255)));
            err_exp++;
         end
         wait_drain("random");
      end
      rand_full = 1'b0;
      repeat (4) @(negedge CLK);
      chk("ops_all_seen", op_exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
